radar_scan_sequencer: RTL

//  Address/beat scheduler for the radar pixel datapath. On a start command it walks frames, channels, rows
//  and column pairs, issuing two pixel coordinates per beat (lane 1 even column, lane 2 odd column).

---
 rtl/radar_seq_pkg.sv | 13 +
 rtl/radar_wrap_counter.sv | 29 ++
 rtl/radar_scan_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/radar_seq_pkg.sv
// Shared types and framing bit positions for the radar scan sequencer.
package radar_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int START_CH  = 0;
    localparam int START_FRM = 1;

endpackage

// File: rtl/radar_wrap_counter.sv
// Wrapping up-counter used as one link of the scan carry chain; last flags the terminal value.
module radar_wrap_counter
    import radar_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 3,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    assign last = (count == WIDTH'(MAX));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/radar_scan_sequencer.sv
// Walks frame/channel/row/column-pair and issues two pixel coordinates per beat with framing markers.
//   state | meaning
//   IDLE  | waiting for start, counters at zero
//   RUN   | beat valid, counters advance on each handshake
//   DONE  | one-cycle done pulse, then back to IDLE
module radar_scan_sequencer
    import radar_seq_pkg::*;
#(
    parameter int FRAME_NUM = 4,
    parameter int IMG_ROWS  = 2048,
    parameter int IMG_COLS  = 2048,
    parameter int NUM_CH    = 5,
    parameter int IDX_W     = 11
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             row_idx1,
    output logic [IDX_W-1:0]             col_idx1,
    output logic [IDX_W-1:0]             row_idx2,
    output logic [IDX_W-1:0]             col_idx2,
    output logic [3:0]                   channel_num,
    output logic [$clog2(FRAME_NUM):0]   frame_idx,
    output logic [1:0]                   data_start,
    output logic [1:0]                   data_end
);

    localparam int FRM_W   = $clog2(FRAME_NUM) + 1;
    localparam int MAX_DIM = (IMG_ROWS > IMG_COLS) ? IMG_ROWS : IMG_COLS;

    if (IMG_COLS % 2 != 0) begin : g_bad_cols
        $error("radar_scan_sequencer: IMG_COLS must be even");
    end
    if (IDX_W < $clog2(MAX_DIM)) begin : g_bad_idx
        $error("radar_scan_sequencer: IDX_W too small for image size");
    end

    seq_state_t state;

    logic             handshake;
    logic             cnt_clr;
    logic             col_en, row_en, ch_en, frm_en;
    logic             col_last, row_last, ch_last, frm_last;
    logic             run_last;
    logic [IDX_W-1:0] col_cnt, row_cnt;
    logic [3:0]       ch_cnt;
    logic [FRM_W-1:0] frm_cnt;

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // abort outranks a same-cycle handshake, so it also blocks the counter advance.
    assign handshake = out_valid && out_ready && !abort;
    assign cnt_clr   = ((state == IDLE) && start) || ((state == RUN) && abort);
    assign col_en    = handshake;
    assign row_en    = col_en && col_last;
    assign ch_en     = row_en && row_last;
    assign frm_en    = ch_en && ch_last;
    assign run_last  = frm_en && frm_last;

    radar_wrap_counter #(.WIDTH(IDX_W), .MAX(IMG_COLS - 2), .STEP(2)) u_col (
        .clock(clock), .reset_n(reset_n), .en(col_en), .clr(cnt_clr),
        .count(col_cnt), .last(col_last)
    );

    radar_wrap_counter #(.WIDTH(IDX_W), .MAX(IMG_ROWS - 1), .STEP(1)) u_row (
        .clock(clock), .reset_n(reset_n), .en(row_en), .clr(cnt_clr),
        .count(row_cnt), .last(row_last)
    );

    radar_wrap_counter #(.WIDTH(4), .MAX(NUM_CH - 1), .STEP(1)) u_ch (
        .clock(clock), .reset_n(reset_n), .en(ch_en), .clr(cnt_clr),
        .count(ch_cnt), .last(ch_last)
    );

    radar_wrap_counter #(.WIDTH(FRM_W), .MAX(FRAME_NUM - 1), .STEP(1)) u_frm (
        .clock(clock), .reset_n(reset_n), .en(frm_en), .clr(cnt_clr),
        .count(frm_cnt), .last(frm_last)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN: begin
                    if (abort)         state <= IDLE;
                    else if (run_last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign row_idx1    = row_cnt;
    assign col_idx1    = col_cnt;
    assign row_idx2    = row_cnt;
    // Lane 2 is held at zero outside a beat so idle outputs read all-zero.
    assign col_idx2    = out_valid ? (col_cnt | IDX_W'(1)) : '0;
    assign channel_num = ch_cnt;
    assign frame_idx   = frm_cnt;

    always_comb begin
        data_start            = 2'b00;
        data_end              = 2'b00;
        data_start[START_CH]  = out_valid && (row_cnt == '0) && (col_cnt == '0);
        data_start[START_FRM] = data_start[START_CH] && (ch_cnt == '0);
        data_end[START_CH]    = out_valid && row_last && col_last;
        data_end[START_FRM]   = data_end[START_CH] && ch_last;
    end

endmodule
